sort_9_drain: RTL

- Output stage placed directly downstream of the 9-input combinational sorter.
- Captures the sorter's 9 parallel sorted words in one cycle, then streams them out one word per beat, smallest first, on a valid/ready interface.
- Signals the final beat of each frame with a last flag and keeps a running count of completed frames.
- Applies back-pressure to the capture side while a frame is being drained.

---
 rtl/sort_9_drain.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sort_9_drain.sv
// -----------------------------------------------------------------------------
// sort_9_drain
//
// Output stage for the 9-input combinational sorter. A frame of nine sorted
// words is captured in one cycle and then streamed out smallest-first, one word
// per beat, on a valid/ready interface. The last beat of every frame is flagged
// and fully drained frames are counted. While a frame is being drained the
// capture side is back-pressured, except on the final beat, where a new frame
// may be loaded so that back-to-back frames run without a bubble.
//
// Optional feature (macro SORT_9_DRAIN_ORDER_CHECK_EN):
//   defined   - each captured frame is checked for ascending (unsigned) order;
//               any violation sets the sticky order_err flag until reset.
//   undefined - no comparators are built and order_err is tied low.
//
// Parameters:
//   W      data word width
//   CNT_W  width of the completed-frame counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       sort_0..sort_8 hold a frame to capture
//   in_ready       frame is captured this cycle if in_valid is high
//   sort_0..sort_8 sorted words from the sorter, sort_0 smallest
//   out_valid      out_data holds a valid beat
//   out_ready      downstream accepts the beat
//   out_data       current word of the frame
//   out_last       current beat is the ninth (final) word
//   frame_count    number of fully drained frames
//   order_err      sticky ordering error flag
// -----------------------------------------------------------------------------
module sort_9_drain #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     sort_0,
  input  logic [W-1:0]     sort_1,
  input  logic [W-1:0]     sort_2,
  input  logic [W-1:0]     sort_3,
  input  logic [W-1:0]     sort_4,
  input  logic [W-1:0]     sort_5,
  input  logic [W-1:0]     sort_6,
  input  logic [W-1:0]     sort_7,
  input  logic [W-1:0]     sort_8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_count,
  output logic             order_err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [W-1:0]     buf_q [9];
  logic [W-1:0]     buf_d [9];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     sort_s [9];
  logic             beat_s;
  logic             last_beat_s;
  logic             capture_s;

  assign sort_s[0] = sort_0;
  assign sort_s[1] = sort_1;
  assign sort_s[2] = sort_2;
  assign sort_s[3] = sort_3;
  assign sort_s[4] = sort_4;
  assign sort_s[5] = sort_5;
  assign sort_s[6] = sort_6;
  assign sort_s[7] = sort_7;
  assign sort_s[8] = sort_8;

  // Handshake qualifiers. in_ready also opens on the last beat so the next
  // frame can be loaded in the same cycle the current one finishes.
  assign beat_s      = out_valid & out_ready;
  assign last_beat_s = beat_s & (idx_q == 4'd8);
  assign in_ready    = rst_n & ((state_q == ST_IDLE) | last_beat_s);
  assign capture_s   = in_valid & in_ready;

  // State, index, frame buffer and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      for (int i = 0; i < 9; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 9; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Next-state logic: a capture always (re)enters DRAIN, even on the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_s) state_d = ST_DRAIN;
        else           state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (last_beat_s && !capture_s) state_d = ST_IDLE;
        else                           state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture wins over beat advance for idx.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 9; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (capture_s) begin
      idx_d = 4'd0;
      for (int i = 0; i < 9; i++) begin
        buf_d[i] = sort_s[i];
      end
    end else if (beat_s && (idx_q != 4'd8)) begin
      idx_d = idx_q + 4'd1;
    end else begin
      idx_d = idx_q;
    end
    if (last_beat_s) cnt_d = cnt_q + CNT_W'(1);
    else             cnt_d = cnt_q;
  end

  // Output decode, driven purely from registered state.
  always_comb begin
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    frame_count = cnt_q;
    if (state_q == ST_DRAIN) begin
      out_valid = 1'b1;
      out_data  = buf_q[idx_q];
      out_last  = (idx_q == 4'd8);
    end else begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
    end
  end

`ifdef SORT_9_DRAIN_ORDER_CHECK_EN
  logic err_q, err_d;

  // True when any adjacent pair of the frame is descending (unsigned).
  function automatic logic frame_out_of_order(input logic [W-1:0] w [9]);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bad = bad | (w[i] > w[i+1]);
    end
    return bad;
  endfunction

  // Sticky error: set by an out-of-order capture, cleared only by reset.
  always_comb begin
    err_d = err_q | (capture_s & frame_out_of_order(sort_s));
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule
